// File: rtl/nibble_alu_acc.sv
// Handshaked add / subtract / burst-accumulate unit with a one-entry registered result channel.
// Build option: define NIBBLE_ALU_SAT_EN to clamp underflowing SUB results to zero.
module nibble_alu_acc #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      a,
  input  logic [WIDTH-1:0]                      b,
  input  logic [1:0]                            mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH+1+$clog2(BURST)-1:0]      result,
  output logic                                  borrow,
  output logic                                  acc_busy
);

  localparam int OUT_W = WIDTH + 1 + $clog2(BURST);
  localparam int CNT_W = $clog2(BURST);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  // Accumulator FSM is encoded by the beat count; this view names its two phases.
  typedef enum logic {
    ACC_EMPTY   = 1'b0,
    ACC_FILLING = 1'b1
  } acc_state_t;

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             borrow_q, borrow_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [OUT_W-1:0] a_ext, b_ext;
  logic [OUT_W-1:0] acc_sum;
  logic [OUT_W-1:0] sub_diff;
  acc_state_t       acc_state;

  // Handshake: a beat moves on in_valid && in_ready; a result moves on out_valid && out_ready.
  // The input stalls only while a held result is not being taken this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign a_ext    = OUT_W'(a);
  assign b_ext    = OUT_W'(b);
  assign acc_sum  = acc_q + a_ext + b_ext;
  assign sub_diff = a_ext - b_ext;

  assign acc_state = (cnt_q == '0) ? ACC_EMPTY : ACC_FILLING;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    borrow_d    = borrow_q;
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      case (mode)
        MODE_ADD: begin
          result_d    = a_ext + b_ext;
          borrow_d    = 1'b0;
          out_valid_d = 1'b1;
        end
        MODE_SUB: begin
          borrow_d    = (a < b);
`ifdef NIBBLE_ALU_SAT_EN
          result_d    = (a < b) ? '0 : sub_diff;
`else
          result_d    = sub_diff;
`endif
          out_valid_d = 1'b1;
        end
        MODE_ACC: begin
          if (cnt_q == CNT_LAST) begin
            result_d    = acc_sum;
            borrow_d    = 1'b0;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_CLR: begin
          acc_d = '0;
          cnt_d = '0;
        end
        default: begin
          acc_d = acc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign borrow    = borrow_q;
  assign acc_busy  = (acc_state == ACC_FILLING);

endmodule

// File: doc/nibble_alu_acc.md
# nibble_alu_acc

Parametrised, handshaked successor to the team's registered nibble adder. Accepts operand pairs over a valid/ready input channel and performs add, subtract, burst-accumulate or clear. Results go out through a one-entry registered output channel with backpressure. It sits between the pad-level input latch and the `uo_out` driver in the Tiny Tapeout top, and is generalised in operand width and accumulation depth.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits.
- `BURST`, default 4: beats per accumulation burst; must be ≥ 2.
- Derived `OUT_W` = `WIDTH + 1 + $clog2(BURST)`: result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`  in  WIDTH  operand A, unsigned.
- `b`  in  WIDTH  operand B, unsigned.
- `mode`  in  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `out_valid`  out  1  `result` holds an unconsumed value.
- `out_ready`  in  1  consumer accepts `result` this cycle.
- `result`  out  OUT_W  result value.
- `borrow`  out  1  set with a SUB result where a < b; 0 for all other results.
- `acc_busy`  out  1  the accumulator holds a partial burst (count ≠ 0).

## Operation
- A beat is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready` (combinational). This gives full throughput when the consumer is ready.
- ADD: loads `result = a + b`, zero-extended to OUT_W, with `borrow = 0`.
- SUB: computes `a - b` in OUT_W bits.
  - Wraps two's-complement unless the Configuration macro selects saturation.
  - `borrow` = (a < b).
- ACC:
  - `acc_next = acc + a + b`.
  - If `cnt == BURST-1`: load `result = acc_next`, `borrow = 0`, then clear `acc` and `cnt` to 0.
  - Otherwise: `acc <= acc_next`, `cnt <= cnt + 1`, and no output is produced.
- CLR: clears `acc` and `cnt` to 0 and produces no output.
- ADD and SUB beats leave `acc` and `cnt` untouched, so they can be interleaved inside a burst.
- Accumulator state machine, encoded by `cnt`:
  - EMPTY (cnt = 0) → FILLING on an ACC beat.
  - FILLING (1..BURST-1) → next count on an ACC beat.
  - At BURST-1, an ACC beat emits the result and returns to EMPTY.
  - CLR forces EMPTY from any state.
- `acc` is OUT_W bits wide. The worst case BURST·2·(2^WIDTH−1) cannot overflow.
- Output register:
  - Set `out_valid` when a result-producing beat is accepted.
  - Clear it on `out_valid && out_ready` when no new result loads in the same cycle.
  - On simultaneous consume and load, the new result replaces the old one and `out_valid` stays 1.
- While `out_valid && !out_ready`: `result` and `borrow` hold stable and `in_ready = 0`. No beat of any mode is accepted, including CLR.

## Timing
- Latency: a result appears one cycle after the accepting edge, i.e. `out_valid` is high on the next cycle.
- ACC latency is measured from the final (BURST-th) beat.
- Reset values: `out_valid` 0, `result` 0, `borrow` 0, `acc` 0, `cnt` 0, `acc_busy` 0. `in_ready` is therefore 1.
- Reset mid-burst or mid-backpressure:
  - The partial accumulation and any pending result are discarded immediately (asynchronous).
  - The first beat after reset deasserts starts a fresh burst.
- `acc_busy` is registered-derived: it is `cnt != 0` and updates on the same edge as `cnt`.
- No combinational path from `a`, `b` or `mode` to any output. `in_ready` depends only on `out_valid` and `out_ready`.

## Configuration
- Macro: `NIBBLE_ALU_SAT_EN`.
- Defined: a SUB with a < b loads `result = 0` and `borrow = 1` (saturating, clamped at zero).
- Undefined: a SUB with a < b loads the two's-complement wrap `(a - b) mod 2^OUT_W` and `borrow = 1`.
- ADD, ACC and CLR behaviour is identical in both builds.

## Test plan
All scenarios use `WIDTH=4`, `BURST=4`, `OUT_W=7`.
- ADD a=9, b=8, with `out_ready=1` → next cycle `out_valid=1`, `result=17`, `borrow=0`. Back-to-back ADD beats are accepted every cycle.
- SUB a=3, b=5 → `borrow=1`; `result=126` without the macro, `result=0` with `NIBBLE_ALU_SAT_EN`. SUB a=12, b=4 → `result=8`, `borrow=0`.
- Four ACC beats of (15,15), with an ADD (1,1) between beats 2 and 3:
  - ADD emits 2 with no effect on the accumulator.
  - A single ACC output of `result=120` follows the fourth ACC beat.
  - `acc_busy` is 1 across the burst and returns to 0 after it.
- Backpressure: with `out_valid=1`, hold `out_ready=0` for 5 cycles while `in_valid=1` → `in_ready=0`, `result` stable, no beats lost. Then raise `out_ready` → the pending result is consumed and the next beat is accepted in the same cycle.
- Two ACC beats (3,4), then CLR, then four ACC beats (1,1) → only one output, `result=8`.
- Two ACC beats, then assert `reset` mid-cycle → all outputs go to 0 immediately. After release, four ACC beats (2,2) → `result=16`.
